bp_update_tracker: RTL
======================

Name: bp_update_tracker

Overview:
- Initiator-side companion to the tournament branch predictor top. Records each prediction issued by the predictor's read port (index and predicted direction) in an in-order queue.
- When the branch resolves in order, it produces the predictor's write-port stream (w_v, idx_w, correct). This closes the training loop the predictor expects.
- Sits between fetch/predict and the branch resolution unit. Also maintains a saturating mispredict count.

Parameters:
- bht_idx_width_p, 9, width of the predictor table index.
- depth_p, 8, number of outstanding predictions tracked; power of two, at least 2.
- cnt_width_p, 16, width of the mispredict counter.

Ports:
- clk_i  input  1  single clock, rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- br_v_i  input  1  a prediction was issued this cycle; capture it.
- br_idx_i  input  bht_idx_width_p  index used for the prediction (the same value driven on idx_r_i).
- br_pred_i  input  1  predicted direction (the predictor's predict_o).
- br_ready_o  output  1  queue can accept a capture; equals not full.
- res_v_i  input  1  oldest outstanding branch resolves this cycle.
- res_taken_i  input  1  actual direction of the resolving branch.
- flush_i  input  1  squash all outstanding (unresolved) predictions.
- w_v_o  output  1  update valid to the predictor write port.
- idx_w_o  output  bht_idx_width_p  index of the resolved branch.
- correct_o  output  1  1 when the prediction matched the outcome.
- occupancy_o  output  clog2(depth_p)+1  number of entries held.
- mispred_cnt_o  output  cnt_width_p  saturating count of mispredicts.
- err_o  output  1  sticky: res_v_i was seen while the queue was empty.

Behaviour:
- Reset (reset_i low, asynchronous): pointers=0, occupancy_o=0, br_ready_o=1, w_v_o=0, idx_w_o=0, correct_o=0, mispred_cnt_o=0, err_o=0. Entry storage need not be reset.
- Storage: circular buffer of depth_p entries {idx, pred}.
  - Read and write pointers are clog2(depth_p)+1 bits; the extra bit distinguishes full from empty.
  - Full when the low bits are equal and the MSBs differ. Empty when all bits are equal.
  - Pointers wrap naturally modulo 2*depth_p.
- Enqueue: occurs on the edge where br_v_i=1, br_ready_o=1 and flush_i=0. Writes {br_idx_i, br_pred_i} at the write pointer, then increments it.
  - br_v_i while full: the capture is dropped, no state changes. br_ready_o is 0 while full, even if a pop occurs in the same cycle; there is no enqueue-through-pop when full.
- Resolve: occurs on the edge where res_v_i=1 and the queue is not empty. Pops the head.
  - Next cycle: w_v_o=1, idx_w_o=head idx, correct_o=(head pred == res_taken_i). Latency is 1 cycle, fully registered.
  - w_v_o is high for exactly one cycle per pop. Back-to-back resolves give back-to-back updates.
  - When w_v_o=0, idx_w_o and correct_o hold their previous values.
- Resolve on empty: no pop, w_v_o=0 next cycle, err_o set to 1 and held until reset.
- Simultaneous enqueue and resolve (not full, not empty): both happen; occupancy is unchanged.
  - Enqueue into an empty queue while res_v_i=1: the new entry is not resolved that cycle (empty-error rule applies).
- Flush: flush_i=1 at an edge clears both pointers to 0 and occupancy to 0.
  - A resolve presented in the same cycle is processed first (its update is emitted next cycle, because the resolving branch caused the flush).
  - An enqueue in the same cycle is discarded.
- Mispredict counter: increments when a pop has pred != taken. It saturates at all-ones (0xFFFF at default) and never wraps.
- occupancy_o is the registered write-pointer minus read-pointer difference, valid at all times.

Test Plan:
- Reset, then enqueue 3 entries (idx 0x010 pred 1, 0x020 pred 0, 0x030 pred 1), then resolve taken=1,1,0 on consecutive cycles -> w_v_o high for 3 consecutive cycles starting 1 cycle after the first resolve; idx/correct = 0x010/1, 0x020/0, 0x030/0; mispred_cnt_o=2; occupancy_o returns to 0.
- Fill to depth_p=8 -> br_ready_o=0, occupancy_o=8. A 9th br_v_i is dropped. Resolve all 8 -> updates come out in capture order. Refill 8 with no gap to exercise pointer wrap.
- Simultaneous br_v_i and res_v_i with occupancy 4 -> occupancy stays 4, update emitted, new entry appended at the tail.
- flush_i with res_v_i and br_v_i all high, occupancy 5 -> one update for the old head next cycle, occupancy_o=0, the enqueued entry is lost. A later resolve sets err_o=1.
- Preload mispred_cnt to 0xFFFE via 3 mispredicting resolves after forcing, or use cnt_width_p=2 -> the counter saturates at max and holds on further mispredicts.
- Assert reset_i low mid-stream with w_v_o=1 -> all outputs go to reset values immediately (asynchronously), br_ready_o=1, err_o=0.

Source files
------------

// File: rtl/bp_update_tracker.sv
// bp_update_tracker: in-order queue of issued branch predictions. On each
// in-order resolve it emits one registered update {w_v, idx_w, correct} for
// the predictor write port, and keeps a saturating mispredict count.
module bp_update_tracker #(
    parameter int unsigned bht_idx_width_p = 9,
    parameter int unsigned depth_p         = 8,
    parameter int unsigned cnt_width_p     = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         br_v_i,
    input  logic [bht_idx_width_p-1:0]   br_idx_i,
    input  logic                         br_pred_i,
    output logic                         br_ready_o,
    input  logic                         res_v_i,
    input  logic                         res_taken_i,
    input  logic                         flush_i,
    output logic                         w_v_o,
    output logic [bht_idx_width_p-1:0]   idx_w_o,
    output logic                         correct_o,
    output logic [$clog2(depth_p):0]     occupancy_o,
    output logic [cnt_width_p-1:0]       mispred_cnt_o,
    output logic                         err_o
);

    localparam int unsigned AddrW = $clog2(depth_p);
    localparam int unsigned PtrW  = AddrW + 1;

    // Entry storage (not reset; only read when the queue is non-empty)
    logic [bht_idx_width_p-1:0] r_idx_mem  [depth_p];
    logic                       r_pred_mem [depth_p];

    logic [PtrW-1:0]            r_wptr;
    logic [PtrW-1:0]            r_rptr;
    logic [PtrW-1:0]            r_occ;
    logic                       r_ready;
    logic                       r_w_v;
    logic [bht_idx_width_p-1:0] r_idx_w;
    logic                       r_correct;
    logic [cnt_width_p-1:0]     r_mispred_cnt;
    logic                       r_err;

    logic                       w_empty;
    logic                       w_enq;
    logic                       w_pop;
    logic                       w_head_pred;
    logic [bht_idx_width_p-1:0] w_head_idx;
    logic                       w_mispred;
    logic [PtrW-1:0]            w_wptr_nxt;
    logic [PtrW-1:0]            w_rptr_nxt;
    logic                       w_full_nxt;

    // Queue status and handshake decode from registered state
    always_comb begin
        w_empty     = (r_wptr == r_rptr);
        w_enq       = br_v_i & r_ready & ~flush_i;
        w_pop       = res_v_i & ~w_empty;
        w_head_idx  = r_idx_mem[r_rptr[AddrW-1:0]];
        w_head_pred = r_pred_mem[r_rptr[AddrW-1:0]];
        w_mispred   = w_pop & (w_head_pred != res_taken_i);
    end

    // Next pointers: flush wins over any same-cycle enqueue/pop movement
    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        if (flush_i) begin
            w_wptr_nxt = '0;
            w_rptr_nxt = '0;
        end else begin
            if (w_enq) w_wptr_nxt = r_wptr + PtrW'(1);
            if (w_pop) w_rptr_nxt = r_rptr + PtrW'(1);
        end
        w_full_nxt = (w_wptr_nxt[AddrW-1:0] == w_rptr_nxt[AddrW-1:0]) &&
                     (w_wptr_nxt[PtrW-1] != w_rptr_nxt[PtrW-1]);
    end

    // Capture a prediction at the tail
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_idx_mem[r_wptr[AddrW-1:0]]  <= br_idx_i;
            r_pred_mem[r_wptr[AddrW-1:0]] <= br_pred_i;
        end
    end

    // Pointers, occupancy and ready, all registered from next-state values
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_ready <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_occ   <= w_wptr_nxt - w_rptr_nxt;
            r_ready <= ~w_full_nxt;
        end
    end

    // Predictor update port; idx/correct hold when no update is issued
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_w_v     <= 1'b0;
            r_idx_w   <= '0;
            r_correct <= 1'b0;
        end else begin
            r_w_v <= w_pop;
            if (w_pop) begin
                r_idx_w   <= w_head_idx;
                r_correct <= (w_head_pred == res_taken_i);
            end
        end
    end

    // Saturating mispredict counter and sticky resolve-on-empty error
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_mispred_cnt <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_mispred && (r_mispred_cnt != {cnt_width_p{1'b1}}))
                r_mispred_cnt <= r_mispred_cnt + cnt_width_p'(1);
            if (res_v_i && w_empty)
                r_err <= 1'b1;
        end
    end

    assign br_ready_o    = r_ready;
    assign occupancy_o   = r_occ;
    assign w_v_o         = r_w_v;
    assign idx_w_o       = r_idx_w;
    assign correct_o     = r_correct;
    assign mispred_cnt_o = r_mispred_cnt;
    assign err_o         = r_err;

endmodule
